// File: rtl/bloco_operativo_pkg.sv
// Shared encodings for the control word driven by the control FSM into the datapath.
package bloco_operativo_pkg;

    // Default datapath width.
    localparam int unsigned W_DEF = 8;

    // Operand A select (m0).
    typedef enum logic [1:0] {
        OPA_X = 2'd0,
        OPA_H = 2'd1,
        OPA_S = 2'd2,
        OPA_K = 2'd3
    } opa_sel_e;

    // Operand B select (m1).
    typedef enum logic [1:0] {
        OPB_X   = 2'd0,
        OPB_XIN = 2'd1,
        OPB_S   = 2'd2,
        OPB_H   = 2'd3
    } opb_sel_e;

    // ALU operation select (m2).
    typedef enum logic [1:0] {
        ALU_PASS = 2'd0,
        ALU_MUL  = 2'd1,
        ALU_ADD  = 2'd2,
        ALU_SUB  = 2'd3
    } alu_op_e;

endpackage

// File: rtl/bloco_operativo_alu.sv
// Combinational shared ALU: pass / multiply (low half) / add / subtract, all unsigned modulo 2^W.
module bo_alu
    import bloco_operativo_pkg::*;
#(
    parameter int unsigned W = W_DEF
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  alu_op_e      op,
    output logic [W-1:0] result,
    output logic         zero
);

    logic [2*W-1:0] product;

    // Full-width product; only the low W bits leave the ALU.
    always_comb begin
        product = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    end

    // Operation select; carries and borrows are discarded.
    always_comb begin
        result = '0;
        unique case (op)
            ALU_PASS: result = a;
            ALU_MUL:  result = product[W-1:0];
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            default:  result = '0;
        endcase
    end

    // Zero flag for the control FSM.
    always_comb begin
        zero = (result == '0);
    end

endmodule

// File: rtl/bloco_operativo.sv
// Datapath: registers X/H/S around a shared ALU, done-edge capture of S and a
// valid/ready output stage with a sticky overflow flag for dropped results.
module bloco_operativo
    import bloco_operativo_pkg::*;
#(
    parameter int unsigned W = W_DEF,
    parameter int unsigned K = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] x_in,
    input  logic [1:0]   m0,
    input  logic [1:0]   m1,
    input  logic [1:0]   m2,
    input  logic         h,
    input  logic         lx,
    input  logic         lh,
    input  logic         ls,
    input  logic         done,
    output logic [W-1:0] y_out,
    output logic         y_valid,
    input  logic         y_ready,
    output logic         zero,
    output logic         ovf_err
);

    localparam logic [W-1:0] K_VAL = W'(K);

    logic [W-1:0] x_q;
    logic [W-1:0] h_q;
    logic [W-1:0] s_q;
    logic         done_q;

    logic [W-1:0] opa;
    logic [W-1:0] opb;
    logic [W-1:0] alu_res;
    logic [W-1:0] wb;
    logic         capture;
    logic         accept;

    // Operand A / B multiplexers.
    always_comb begin
        opa = '0;
        opb = '0;
        unique case (opa_sel_e'(m0))
            OPA_X:   opa = x_q;
            OPA_H:   opa = h_q;
            OPA_S:   opa = s_q;
            OPA_K:   opa = K_VAL;
            default: opa = '0;
        endcase
        unique case (opb_sel_e'(m1))
            OPB_X:   opb = x_q;
            OPB_XIN: opb = x_in;
            OPB_S:   opb = s_q;
            OPB_H:   opb = h_q;
            default: opb = '0;
        endcase
    end

    bo_alu #(
        .W (W)
    ) u_alu (
        .a      (opa),
        .b      (opb),
        .op     (alu_op_e'(m2)),
        .result (alu_res),
        .zero   (zero)
    );

    // Write-back source, done rising-edge detect and handshake accept.
    always_comb begin
        wb      = h ? alu_res : x_in;
        capture = done & ~done_q;
        accept  = y_valid & y_ready;
    end

    // Register file: every enabled register loads the same write-back value.
    always_ff @(posedge clk) begin
        if (reset) begin
            x_q <= '0;
            h_q <= '0;
            s_q <= '0;
        end else begin
            if (lx) x_q <= wb;
            if (lh) h_q <= wb;
            if (ls) s_q <= wb;
        end
    end

    // Output stage: capture uses pre-edge S; a capture blocked by backpressure
    // leaves the held result untouched and raises the sticky overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            done_q  <= 1'b0;
            y_out   <= '0;
            y_valid <= 1'b0;
            ovf_err <= 1'b0;
        end else begin
            done_q <= done;
            if (capture) begin
                if (!y_valid || accept) begin
                    y_out   <= s_q;
                    y_valid <= 1'b1;
                end else begin
                    ovf_err <= 1'b1;
                end
            end else if (accept) begin
                y_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bloco_operativo.sv
// Self-checking bench: directed scenarios then random control words, all
// checked against a transaction-level reference model.
module tb_bloco_operativo;

    localparam int unsigned W  = 8;
    localparam int unsigned K  = 1;
    localparam int unsigned MOD = 256;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] x_in;
    logic [1:0]   m0, m1, m2;
    logic         h, lx, lh, ls, done, y_ready;
    logic [W-1:0] y_out;
    logic         y_valid, zero, ovf_err;

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    int unsigned r_x, r_h, r_s;
    bit          r_done_prev;
    int unsigned r_y;
    bit          r_valid, r_ovf;

    bloco_operativo #(.W(W), .K(K)) dut (
        .clk     (clk),
        .reset   (reset),
        .x_in    (x_in),
        .m0      (m0),
        .m1      (m1),
        .m2      (m2),
        .h       (h),
        .lx      (lx),
        .lh      (lh),
        .ls      (ls),
        .done    (done),
        .y_out   (y_out),
        .y_valid (y_valid),
        .y_ready (y_ready),
        .zero    (zero),
        .ovf_err (ovf_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int unsigned model_alu();
        int unsigned a, b;
        int unsigned sel_a[4];
        int unsigned sel_b[4];
        sel_a = '{r_x, r_h, r_s, K};
        sel_b = '{r_x, int'(x_in), r_s, r_h};
        a = sel_a[m0];
        b = sel_b[m1];
        case (m2)
            2'd0:    return a % MOD;
            2'd1:    return (a * b) % MOD;
            2'd2:    return (a + b) % MOD;
            default: return (a + MOD - b) % MOD;
        endcase
    endfunction

    task automatic set_ctrl(input int a, input int b, input int op, input bit hh,
                            input bit l_x, input bit l_h, input bit l_s);
        m0 = 2'(a); m1 = 2'(b); m2 = 2'(op);
        h = hh; lx = l_x; lh = l_h; ls = l_s;
    endtask

    // One clock: check zero before the edge, advance the model, check state after.
    task automatic tick();
        int unsigned alu, wbv;
        bit rise;
        #1;
        alu = model_alu();
        if (!reset) chk("zero", zero, (alu == 0));
        wbv = h ? alu : int'(x_in);
        if (reset) begin
            r_x = 0; r_h = 0; r_s = 0; r_done_prev = 0;
            r_y = 0; r_valid = 0; r_ovf = 0;
        end else begin
            rise = done && !r_done_prev;
            if (rise) begin
                if (!r_valid || y_ready) begin
                    r_y = r_s; r_valid = 1;
                end else begin
                    r_ovf = 1;
                end
            end else if (r_valid && y_ready) begin
                r_valid = 0;
            end
            r_done_prev = done;
            if (lx) r_x = wbv;
            if (lh) r_h = wbv;
            if (ls) r_s = wbv;
        end
        @(posedge clk);
        #1;
        chk("X", dut.x_q, r_x);
        chk("H", dut.h_q, r_h);
        chk("S", dut.s_q, r_s);
        chk("y_out", y_out, r_y);
        chk("y_valid", y_valid, r_valid);
        chk("ovf_err", ovf_err, r_ovf);
    endtask

    initial begin
        r_x = 0; r_h = 0; r_s = 0; r_done_prev = 0; r_y = 0; r_valid = 0; r_ovf = 0;
        done = 0; y_ready = 0; x_in = 8'hFF;
        @(negedge clk);

        // 1. Reset beats load enables.
        reset = 1; set_ctrl(0, 0, 0, 0, 1, 1, 1);
        tick();
        chk("rst_S", dut.s_q, 0);
        chk("rst_valid", y_valid, 0);
        reset = 0;

        // 2. Load X=5, S=X*X=25, then S - x_in (30) wraps to 251, captured in H.
        x_in = 5; set_ctrl(0, 0, 0, 0, 1, 0, 0); tick();
        set_ctrl(0, 0, 1, 1, 0, 0, 1); tick();
        chk("mul_S", dut.s_q, 25);
        x_in = 30; set_ctrl(2, 1, 3, 1, 0, 1, 0); tick();
        chk("sub_wrap_H", dut.h_q, 251);
        set_ctrl(0, 0, 0, 0, 0, 0, 0);

        // 3. Done held two cycles with backpressure: one capture of 25.
        y_ready = 0; done = 1; tick();
        chk("cap_valid", y_valid, 1);
        chk("cap_y", y_out, 25);
        tick();
        chk("cap_once_ovf", ovf_err, 0);

        // 4. New capture while stalled: result dropped, overflow set; then drain.
        done = 0; x_in = 7; set_ctrl(0, 0, 0, 0, 0, 0, 1); tick();
        set_ctrl(0, 0, 0, 0, 0, 0, 0);
        done = 1; tick();
        chk("bp_y_hold", y_out, 25);
        chk("bp_ovf", ovf_err, 1);
        done = 0; y_ready = 1; tick();
        chk("drain_valid", y_valid, 0);

        // 5. Accept and capture on the same edge.
        y_ready = 0; done = 1; tick();
        done = 0; x_in = 9; set_ctrl(0, 0, 0, 0, 0, 0, 1); tick();
        set_ctrl(0, 0, 0, 0, 0, 0, 0);
        y_ready = 1; done = 1; tick();
        chk("acc_cap_valid", y_valid, 1);
        chk("acc_cap_y", y_out, 9);
        chk("acc_cap_ovf", ovf_err, 1);

        // 6. Reset one cycle after a done rise discards the result.
        done = 0; y_ready = 0; tick();
        done = 1; tick();
        reset = 1; tick();
        chk("midrst_valid", y_valid, 0);
        chk("midrst_y", y_out, 0);
        chk("midrst_S", dut.s_q, 0);
        chk("midrst_ovf", ovf_err, 0);
        reset = 0; done = 0;

        // Random control words.
        for (int i = 0; i < 400; i++) begin
            reset   = ($urandom_range(0, 39) == 0);
            x_in    = W'($urandom);
            set_ctrl(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                     1'($urandom), 1'($urandom));
            done    = ($urandom_range(0, 2) != 0);
            y_ready = 1'($urandom);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
